// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake between the boot/UART byte source (master) and the loader (slave).
interface instr_mem_loader_if;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a little-endian byte stream into words and issues one write per word at sequential addresses.
// Optional LOADER_CHECKSUM_EN adds o_checksum, the mod-256 sum of accepted bytes since start.
module instr_mem_loader #(
  parameter int unsigned BYTE_SIZE  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  instr_mem_loader_if.slave         s_in,
  output logic                      o_we,
  output logic [ADDR_WIDTH-1:0]     o_addr,
  output logic [BYTE_SIZE*8-1:0]    o_wd,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_ovf,
  output logic [ADDR_WIDTH-1:0]     o_word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]                o_checksum
`endif
);

  localparam int unsigned WD_W  = BYTE_SIZE * 8;
  localparam int unsigned IDX_W = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_in_ready, r_we, r_busy, r_done, r_ovf, r_last_seen;
  logic [ADDR_WIDTH-1:0] r_addr, r_word_count;
  logic [WD_W-1:0]       r_wd;
  logic [IDX_W-1:0]      r_idx;

  logic [ADDR_WIDTH-1:0] w_addr_nxt, w_word_count_nxt, w_addr_inc;
  logic [WD_W-1:0]       w_wd_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_ovf_nxt, w_last_seen_nxt, w_accept;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_checksum, w_checksum_nxt;
`endif

  assign w_accept   = s_in.valid && r_in_ready;
  assign w_addr_inc = r_addr + ADDR_WIDTH'(BYTE_SIZE);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_word_count_nxt = r_word_count;
    w_wd_nxt         = r_wd;
    w_idx_nxt        = r_idx;
    w_ovf_nxt        = r_ovf;
    w_last_seen_nxt  = r_last_seen;
`ifdef LOADER_CHECKSUM_EN
    w_checksum_nxt   = r_checksum;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt      = S_COLLECT;
          w_addr_nxt       = ADDR_WIDTH'(BASE_ADDR);
          w_word_count_nxt = '0;
          w_ovf_nxt        = 1'b0;
          w_wd_nxt         = '0;
          w_idx_nxt        = '0;
          w_last_seen_nxt  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          w_checksum_nxt   = '0;
`endif
        end
      end
      S_COLLECT: begin
        if (w_accept) begin
          for (int unsigned i = 0; i < BYTE_SIZE; i++) begin
            if (r_idx == IDX_W'(i)) w_wd_nxt[8*i +: 8] = s_in.data;
          end
          w_idx_nxt = r_idx + IDX_W'(1);
`ifdef LOADER_CHECKSUM_EN
          w_checksum_nxt = r_checksum + s_in.data;
`endif
          if ((r_idx == IDX_W'(BYTE_SIZE - 1)) || s_in.last) begin
            w_state_nxt     = S_WRITE;
            w_last_seen_nxt = s_in.last;
          end
        end
      end
      S_WRITE: begin
        w_word_count_nxt = r_word_count + ADDR_WIDTH'(1);
        w_wd_nxt         = '0;
        w_idx_nxt        = '0;
        if (w_addr_inc == ADDR_WIDTH'(MEM_BYTES)) begin
          w_addr_nxt = '0;
          w_ovf_nxt  = 1'b1;
        end else begin
          w_addr_nxt = w_addr_inc;
        end
        w_state_nxt = r_last_seen ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; strobes follow the state being entered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_ready   <= 1'b0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
      r_last_seen  <= 1'b0;
      r_addr       <= '0;
      r_word_count <= '0;
      r_wd         <= '0;
      r_idx        <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_checksum   <= '0;
`endif
    end else begin
      r_in_ready   <= (w_state_nxt == S_COLLECT);
      r_we         <= (w_state_nxt == S_WRITE);
      r_busy       <= (w_state_nxt == S_COLLECT) || (w_state_nxt == S_WRITE);
      r_done       <= (w_state_nxt == S_DONE);
      r_ovf        <= w_ovf_nxt;
      r_last_seen  <= w_last_seen_nxt;
      r_addr       <= w_addr_nxt;
      r_word_count <= w_word_count_nxt;
      r_wd         <= w_wd_nxt;
      r_idx        <= w_idx_nxt;
`ifdef LOADER_CHECKSUM_EN
      r_checksum   <= w_checksum_nxt;
`endif
    end
  end

  assign s_in.ready   = r_in_ready;
  assign o_we         = r_we;
  assign o_addr       = r_addr;
  assign o_wd         = r_wd;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_ovf        = r_ovf;
  assign o_word_count = r_word_count;
`ifdef LOADER_CHECKSUM_EN
  assign o_checksum   = r_checksum;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench: the byte driver models packing/addressing and queues expected writes,
// per-DUT monitors pop and compare on every write strobe.
module tb_instr_mem_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, valid = 1'b0, last = 1'b0, sel = 1'b0;
  logic [7:0] data = 8'h00;
  always #5 clk = ~clk;

  instr_mem_loader_if ifa ();
  instr_mem_loader_if ifb ();
  assign ifa.valid = valid;
  assign ifa.data  = data;
  assign ifa.last  = last;
  assign ifb.valid = valid;
  assign ifb.data  = data;
  assign ifb.last  = last;

  logic        we_a, busy_a, done_a, ovf_a, we_b, busy_b, done_b, ovf_b;
  logic [31:0] addr_a, wd_a, wc_a, addr_b, wd_b, wc_b;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  cks_a, cks_b;
`endif

  instr_mem_loader dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start & ~sel), .s_in(ifa.slave),
    .o_we(we_a), .o_addr(addr_a), .o_wd(wd_a), .o_busy(busy_a), .o_done(done_a),
    .o_ovf(ovf_a), .o_word_count(wc_a)
`ifdef LOADER_CHECKSUM_EN
    , .o_checksum(cks_a)
`endif
  );

  instr_mem_loader #(.MEM_BYTES(16), .BASE_ADDR(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start & sel), .s_in(ifb.slave),
    .o_we(we_b), .o_addr(addr_b), .o_wd(wd_b), .o_busy(busy_b), .o_done(done_b),
    .o_ovf(ovf_b), .o_word_count(wc_b)
`ifdef LOADER_CHECKSUM_EN
    , .o_checksum(cks_b)
`endif
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [7:0]  img[$];
  logic [31:0] m_addr, m_word, m_base, m_mem;
  logic [7:0]  m_cks;
  int          m_k;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      if (qa.size() == 0) check_eq("unexpected_we_a", 64'(we_a), 64'd0);
      else begin
        exp_t e;
        e = qa.pop_front();
        check_eq("addr_a", 64'(addr_a), 64'(e.addr));
        check_eq("wd_a", 64'(wd_a), 64'(e.wd));
      end
    end
    if (we_b === 1'b1) begin
      if (qb.size() == 0) check_eq("unexpected_we_b", 64'(we_b), 64'd0);
      else begin
        exp_t e;
        e = qb.pop_front();
        check_eq("addr_b", 64'(addr_b), 64'(e.addr));
        check_eq("wd_b", 64'(wd_b), 64'(e.wd));
      end
    end
  end

  task automatic do_start(input logic s);
    sel = s;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    m_base = s ? 32'd8 : 32'd0;
    m_mem  = s ? 32'd16 : 32'd4096;
    m_addr = m_base;
    m_word = '0;
    m_k    = 0;
    m_cks  = '0;
  endtask

  // Drive img[] with optional random gaps; queue each expected word as its closing byte is accepted
  task automatic send(input int gap_pct, input bit with_last, input bit start_pulse);
    int   i, budget;
    logic v, rdy, lb;
    bit   pulsed;
    i = 0; budget = 0; pulsed = 0;
    while (i < img.size()) begin
      @(negedge clk);
      v   = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      lb  = with_last && (i == img.size() - 1);
      rdy = sel ? ifb.ready : ifa.ready;
      valid = v;
      data  = img[i];
      last  = lb;
      start = start_pulse && !pulsed && (i == 3);
      if (start) pulsed = 1;
      if (v && rdy) begin
        m_word = m_word | (32'(img[i]) << (8 * m_k));
        m_cks  = m_cks + img[i];
        m_k++;
        if (m_k == 4 || lb) begin
          exp_t e;
          e.addr = m_addr;
          e.wd   = m_word;
          if (sel) qb.push_back(e);
          else     qa.push_back(e);
          m_addr = (m_addr + 32'd4 == m_mem) ? 32'd0 : m_addr + 32'd4;
          m_word = '0;
          m_k    = 0;
        end
        i++;
      end
      budget++;
      if (budget > 1000) begin
        check_eq("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if ((sel ? done_b : done_a) === 1'b1) seen = 1;
    end
    check_eq(tag, 64'(seen), 64'd1);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 64'(sel ? done_b : done_a), 64'd0);
  endtask

  initial begin
    // Reset held with stimulus active
    start = 1'b1; valid = 1'b1; last = 1'b1; data = 8'h5A;
    repeat (3) @(negedge clk);
    check_eq("rst_we", 64'({we_a, we_b}), 64'd0);
    check_eq("rst_ready", 64'({ifa.ready, ifb.ready}), 64'd0);
    check_eq("rst_addr", 64'(addr_a | addr_b), 64'd0);
    check_eq("rst_wd", 64'(wd_a | wd_b), 64'd0);
    check_eq("rst_flags", 64'({busy_a, done_a, ovf_a, busy_b, done_b, ovf_b}), 64'd0);
    check_eq("rst_wc", 64'(wc_a | wc_b), 64'd0);
    start = 1'b0; valid = 1'b0; last = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Two full words
    do_start(1'b0);
    check_eq("busy_collect", 64'(busy_a), 64'd1);
    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send(0, 1'b1, 1'b0);
    wait_done("done_s2");
    check_eq("wc_s2", 64'(wc_a), 64'd2);
    check_eq("addr_hold_s2", 64'(addr_a), 64'd8);
    check_eq("ovf_s2", 64'(ovf_a), 64'd0);
    check_eq("busy_idle_s2", 64'(busy_a), 64'd0);

    // Partial final word
    do_start(1'b0);
    img = '{8'hAA, 8'hBB};
    send(0, 1'b1, 1'b0);
    wait_done("done_s3");
    check_eq("wc_s3", 64'(wc_a), 64'd1);

    // Address wrap in a 16-byte memory starting at 8
    do_start(1'b1);
    img = '{};
    for (int k = 0; k < 12; k++) img.push_back(8'(8'h11 * k + 8'h03));
    send(0, 1'b1, 1'b0);
    wait_done("done_s4");
    check_eq("wc_s4", 64'(wc_b), 64'd3);
    check_eq("ovf_s4", 64'(ovf_b), 64'd1);
    check_eq("addr_s4", 64'(addr_b), 64'd4);

    // Gapped valid with a stray start mid-load
    do_start(1'b0);
    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send(40, 1'b1, 1'b1);
    wait_done("done_s5");
    check_eq("wc_s5", 64'(wc_a), 64'd2);
    check_eq("addr_s5", 64'(addr_a), 64'd8);
`ifdef LOADER_CHECKSUM_EN
    check_eq("checksum_s5", 64'(cks_a), 64'(m_cks));
`endif

    // Reset mid-word discards the partial word
    do_start(1'b0);
    img = '{8'h11, 8'h22};
    send(0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_we", 64'(we_a), 64'd0);
    check_eq("abort_busy", 64'(busy_a), 64'd0);
    check_eq("abort_ready", 64'(ifa.ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start(1'b0);
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    send(0, 1'b1, 1'b0);
    wait_done("done_s6");
    check_eq("wc_s6", 64'(wc_a), 64'd1);

    repeat (3) @(negedge clk);
    check_eq("qa_drained", 64'(qa.size()), 64'd0);
    check_eq("qb_drained", 64'(qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
